// File: rtl/quant_table_sequencer_pkg.sv
// Shared constants and types for the quantisation table sequencer.
package quant_table_sequencer_pkg;

    localparam int DEF_N     = 2;
    localparam int DEF_QW    = 10;
    localparam int Q_ENTRIES = 64;
    localparam int BEATS     = Q_ENTRIES / DEF_N;
    localparam int ADDR_W    = 6;

    typedef logic [DEF_QW-1:0] q_entry_t;

    typedef enum logic [1:0] {
        QS_IDLE    = 2'd0,
        QS_PENDING = 2'd1,
        QS_SPLIT   = 2'd2
    } qs_state_t;

endpackage

// File: rtl/quant_table_sequencer_if.sv
// Configuration and stream-side bundle of the quantisation table sequencer.
//
// Handshake: cfg_we / cfg_commit are acted on only in a cycle where cfg_ready
// is 1 (and en is 1); otherwise they are dropped, never held. The beat streams
// have no backpressure: every cycle with *_valid=1 is a beat, and d_denom /
// m_mult answer it combinationally in that same cycle.
interface quant_table_sequencer_if
    import quant_table_sequencer_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int QW = DEF_QW
) ();

    logic                   cfg_we;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [QW-1:0]          cfg_data;
    logic                   cfg_commit;
    logic                   cfg_ready;

    logic                   d_valid;
    logic                   d_sob;
    logic                   d_sof;
    logic [N-1:0][QW-1:0]   d_denom;

    logic                   m_valid;
    logic                   m_sob;
    logic                   m_sof;
    logic [N-1:0][QW-1:0]   m_mult;

    logic                   proto_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_commit,
        output d_valid, d_sob, d_sof, m_valid, m_sob, m_sof,
        input  cfg_ready, d_denom, m_mult, proto_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  d_valid, d_sob, d_sof, m_valid, m_sob, m_sof,
        output cfg_ready, d_denom, m_mult, proto_err
    );

endinterface

// File: rtl/quant_table_sequencer_beat_tracker.sv
// Per-stream beat position tracker: lookup index and framing-error detection.
module quant_table_sequencer_beat_tracker
    import quant_table_sequencer_pkg::*;
#(
    parameter int BEATS_P = BEATS,
    parameter int CW      = $clog2(BEATS_P)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          valid,
    input  logic          sob,
    input  logic          sof,
    output logic [CW-1:0] idx,
    output logic          err
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next beat position: sob restarts at 1 (this beat is beat 0), else advance and wrap
    always_comb begin
        cnt_d = cnt_q;
        if (en && valid) begin
            if (sob) begin
                cnt_d = CW'(1);
            end else if (cnt_q == CW'(BEATS_P - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Beat position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lookup index and framing check (sob early, sob missing, sof without sob)
    always_comb begin
        idx = (valid && sob) ? '0 : cnt_q;
        err = valid && ((sob && (cnt_q != '0)) ||
                        (!sob && (cnt_q == '0)) ||
                        (sof && !sob));
    end

endmodule

// File: rtl/quant_table_sequencer.sv
// Double-banked quantisation table with frame-aligned swap on each stream side.
module quant_table_sequencer
    import quant_table_sequencer_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int QW = DEF_QW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    quant_table_sequencer_if.slave  bus,
    output qs_state_t               dbg_state
);

    localparam int BEATS_L = Q_ENTRIES / N;
    localparam int CW      = $clog2(BEATS_L);

    logic [QW-1:0] bank_q [2][Q_ENTRIES];
    logic [QW-1:0] bank_d [2][Q_ENTRIES];
    qs_state_t     state_q, state_d;
    logic          d_bank_q, d_bank_d;
    logic          m_bank_q, m_bank_d;
    logic          proto_err_q, proto_err_d;
    logic [CW-1:0] d_idx, m_idx;
    logic          d_err, m_err;
    logic          d_sel, m_sel;
    logic          d_sof_hit, m_sof_hit;

    quant_table_sequencer_beat_tracker #(.BEATS_P(BEATS_L)) u_d_track (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .valid (bus.d_valid),
        .sob   (bus.d_sob),
        .sof   (bus.d_sof),
        .idx   (d_idx),
        .err   (d_err)
    );

    quant_table_sequencer_beat_tracker #(.BEATS_P(BEATS_L)) u_m_track (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .valid (bus.m_valid),
        .sob   (bus.m_sob),
        .sof   (bus.m_sof),
        .idx   (m_idx),
        .err   (m_err)
    );

    assign d_sof_hit = bus.d_valid && bus.d_sof;
    assign m_sof_hit = bus.m_valid && bus.m_sof;

    // Bank FSM next state, shadow writes and the framing-error pulse
    always_comb begin
        state_d     = state_q;
        d_bank_d    = d_bank_q;
        m_bank_d    = m_bank_q;
        proto_err_d = 1'b0;
        bank_d      = bank_q;
        if (en) begin
            proto_err_d = d_err || m_err;
            case (state_q)
                QS_IDLE: begin
                    // A write in the commit cycle still lands before the swap request.
                    if (bus.cfg_we) begin
                        bank_d[~d_bank_q][bus.cfg_addr] =
                            (bus.cfg_data == '0) ? QW'(1) : bus.cfg_data;
                    end
                    if (bus.cfg_commit) begin
                        state_d = QS_PENDING;
                    end
                end
                QS_PENDING: begin
                    if (d_sof_hit) begin
                        d_bank_d = ~d_bank_q;
                        state_d  = QS_SPLIT;
                    end
                end
                QS_SPLIT: begin
                    if (m_sof_hit) begin
                        m_bank_d = d_bank_q;
                        state_d  = QS_IDLE;
                    end
                    // The m side lagged a whole frame: force it over and flag it.
                    if (d_sof_hit) begin
                        m_bank_d    = d_bank_q;
                        state_d     = QS_IDLE;
                        proto_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = QS_IDLE;
                end
            endcase
        end
    end

    // Bank FSM and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= QS_IDLE;
            d_bank_q    <= 1'b0;
            m_bank_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_bank_q    <= d_bank_d;
            m_bank_q    <= m_bank_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Table storage, both banks reset to identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < Q_ENTRIES; a++) begin
                    bank_q[b][a] <= QW'(1);
                end
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    // Bank select: the sof beat that triggers a swap already reads the new table
    always_comb begin
        d_sel = (en && (state_q == QS_PENDING) && d_sof_hit) ? ~d_bank_q : d_bank_q;
        m_sel = (en && (state_q == QS_SPLIT) && m_sof_hit) ? d_bank_q : m_bank_q;
    end

    // Per-lane read muxes: lane i of beat k is coefficient N*k+i
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.d_denom[i] = bank_q[d_sel][ADDR_W'(N * int'(d_idx) + i)];
            bus.m_mult[i]  = bank_q[m_sel][ADDR_W'(N * int'(m_idx) + i)];
        end
    end

    assign bus.cfg_ready = (state_q == QS_IDLE);
    assign bus.proto_err = proto_err_q;
    assign dbg_state     = state_q;

endmodule
